// File: rtl/bundler_bits_stream.sv
// Streaming majority bundler: accumulates a run-time number of PAR_BITS-wide
// chunks into per-bit ones counters, resolves each bit by majority with a
// selectable tie-break, and presents the bundled chunk on a valid/ready port.
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// where valid and ready are both high. in_ready is a pure function of state
// (high only while accumulating) and never depends on in_valid. out_valid is
// likewise a pure function of state and, once high, stays high with out_bits
// stable until out_ready is seen high on a clock edge.
module bundler_bits_stream #(
    parameter int MAX_HVS  = 8,
    parameter int PAR_BITS = 2,
    parameter int TIE_MODE = 0,
    localparam int CW      = $clog2(MAX_HVS + 1)
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                start,
    input  logic [CW-1:0]       num_hvs,
    input  logic [PAR_BITS-1:0] tie_bits,
    input  logic                in_valid,
    input  logic [PAR_BITS-1:0] in_bits,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PAR_BITS-1:0] out_bits,
    output logic                busy,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_RESOLVE = 2'd2,
        S_OUT     = 2'd3
    } state_e;

    localparam logic [CW-1:0] MAX_C = CW'(MAX_HVS);

    state_e state_q, state_d;

    // Bundle length, beats taken so far, per-bit ones counts, tie values.
    logic [CW-1:0]                n_q, n_d;
    logic [CW-1:0]                beat_q, beat_d;
    logic [PAR_BITS-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [PAR_BITS-1:0]          tie_q, tie_d;
    logic [PAR_BITS-1:0]          out_bits_q, out_bits_d;

    logic [CW-1:0]       n_clamp;
    logic                beat_fire;
    logic                last_beat;
    logic [PAR_BITS-1:0] resolved;

    // Requested counts above the counter range are clamped to MAX_HVS.
    assign n_clamp   = (num_hvs > MAX_C) ? MAX_C : num_hvs;
    assign beat_fire = (state_q == S_ACCUM) && in_valid;
    // beat_q < n_q <= MAX_HVS < 2^CW, so beat_q + 1 never wraps.
    assign last_beat = beat_fire && ((beat_q + CW'(1)) == n_q);

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (n_clamp == '0) ? S_RESOLVE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (last_beat) begin
                    state_d = S_RESOLVE;
                end
            end
            S_RESOLVE: begin
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        in_ready  = (state_q == S_ACCUM);
        out_valid = (state_q == S_OUT);
        busy      = (state_q != S_IDLE);
        out_bits  = out_bits_q;
        dbg_state = state_q;
    end

    // Per-bit majority: compare 2*cnt against n in CW+1 bits so the doubled
    // count cannot overflow; an exact half takes the tie register bit.
    always_comb begin
        resolved = '0;
        for (int i = 0; i < PAR_BITS; i++) begin
            if ({cnt_q[i], 1'b0} > {1'b0, n_q}) begin
                resolved[i] = 1'b1;
            end else if ({cnt_q[i], 1'b0} < {1'b0, n_q}) begin
                resolved[i] = 1'b0;
            end else begin
                resolved[i] = tie_q[i];
            end
        end
    end

    // Datapath next-state: latch setup on start, count beats, capture result.
    always_comb begin
        n_d        = n_q;
        beat_d     = beat_q;
        cnt_d      = cnt_q;
        tie_d      = tie_q;
        out_bits_d = out_bits_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d    = n_clamp;
                    beat_d = '0;
                    cnt_d  = '0;
                    // In first-beat mode the tie register starts at zero so a
                    // zero-length bundle resolves to all zeros.
                    tie_d  = (TIE_MODE == 0) ? tie_bits : '0;
                end
            end
            S_ACCUM: begin
                if (beat_fire) begin
                    for (int i = 0; i < PAR_BITS; i++) begin
                        cnt_d[i] = cnt_q[i] + CW'(in_bits[i]);
                    end
                    beat_d = beat_q + CW'(1);
                    if ((TIE_MODE == 1) && (beat_q == '0)) begin
                        tie_d = in_bits;
                    end
                end
            end
            S_RESOLVE: begin
                out_bits_d = resolved;
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any partial bundle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            n_q        <= '0;
            beat_q     <= '0;
            cnt_q      <= '0;
            tie_q      <= '0;
            out_bits_q <= '0;
        end else begin
            n_q        <= n_d;
            beat_q     <= beat_d;
            cnt_q      <= cnt_d;
            tie_q      <= tie_d;
            out_bits_q <= out_bits_d;
        end
    end

endmodule
